// File: rtl/sync_frame_tx_pkg.sv
// sync_frame_tx_pkg: frame constants and state encoding for the framed serial
// link. The transmitter and the hunting receiver import these definitions, so
// both ends use the same head pattern and check interval.
package sync_frame_tx_pkg;

  localparam int           BYTE_W       = 8;
  localparam int           FRAME_LEN    = 64;
  localparam int           HEAD_LEN     = 8;
  localparam logic [7:0]   HEAD_PATTERN = 8'b0111_1110;
  localparam logic [7:0]   FILL_BYTE    = 8'h00;
  localparam int           PAY_BYTES    = (FRAME_LEN - HEAD_LEN) / BYTE_W;

  // Receiver side: heads are expected every FRAME_LEN bits. A corrupted head
  // is the bitwise inverse of the real one.
  localparam int           SYNC_CHECK_INTERVAL = FRAME_LEN;
  localparam logic [7:0]   HEAD_PATTERN_BAD    = ~HEAD_PATTERN;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAD    = 2'd1,
    PAYLOAD = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_frame_tx_bytebuf.sv
// sync_frame_tx_bytebuf: one-entry holding register between the payload
// valid/ready interface and the transmitter's shift register.
//   clk_out, rst_n : clock, synchronous active-low reset
//   pay_data/pay_valid/pay_ready : upstream byte handshake
//   enable    : transmitter wants bytes (tx_en || tx_busy)
//   pop       : shift register takes the held byte this cycle
//   buf_valid/buf_data : held byte
module sync_frame_tx_bytebuf
  import sync_frame_tx_pkg::*;
(
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] pay_data,
  input  logic              pay_valid,
  input  logic              enable,
  input  logic              pop,
  output logic              pay_ready,
  output logic              buf_valid,
  output logic [BYTE_W-1:0] buf_data
);

  // Ready only while empty, so a pop and a refill never share a cycle.
  assign pay_ready = rst_n && !buf_valid && enable;

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (pay_valid && pay_ready) begin
      buf_valid <= 1'b1;
      buf_data  <= pay_data;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter. Each frame is a HEAD_LEN-bit head
// followed by payload bytes (MSB first), one bit per clk_out cycle. Missing
// payload bytes are replaced by FILL_BYTE; err_inject inverts the next head.
//   clk_out, rst_n : clock, synchronous active-low reset
//   tx_en          : enable framing, sampled at frame boundaries
//   pay_data/pay_valid/pay_ready : payload byte handshake
//   err_inject     : request an inverted head on the next frame
//   data_out       : registered serial line
//   frame_start    : high while data_out carries head bit 0
//   underrun       : high while data_out carries the MSB of a fill byte
//   tx_busy        : high in HEAD/PAYLOAD
module sync_frame_tx
  import sync_frame_tx_pkg::*;
#(
  parameter int                    FRAME_LEN    = sync_frame_tx_pkg::FRAME_LEN,
  parameter int                    HEAD_LEN     = sync_frame_tx_pkg::HEAD_LEN,
  parameter logic [HEAD_LEN-1:0]   HEAD_PATTERN = sync_frame_tx_pkg::HEAD_PATTERN,
  parameter logic [BYTE_W-1:0]     FILL_BYTE    = sync_frame_tx_pkg::FILL_BYTE
) (
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic [BYTE_W-1:0] pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic              err_inject,
  output logic              data_out,
  output logic              frame_start,
  output logic              underrun,
  output logic              tx_busy
);

  localparam int CW = $clog2(FRAME_LEN);

  tx_state_e           state, state_nxt;
  logic [CW-1:0]       bit_cnt, cnt_nxt;
  logic                inj_flag, inj_nxt;
  logic                inv_r, inv_nxt;
  logic [BYTE_W-1:0]   shreg, sh_nxt;
  logic [HEAD_LEN-1:0] head_sh;
  logic                d_nxt, fs_nxt, ur_nxt;
  logic                start_nxt, load_nxt, pop;
  logic                buf_valid;
  logic [BYTE_W-1:0]   buf_data;

  assign tx_busy = (state != IDLE);

  sync_frame_tx_bytebuf u_buf (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .enable    (tx_en || tx_busy),
    .pop       (pop),
    .pay_ready (pay_ready),
    .buf_valid (buf_valid),
    .buf_data  (buf_data)
  );

  // State register. The line outputs are registered one step ahead so that
  // data_out/frame_start/underrun line up with the state and bit_cnt they
  // describe.
  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      inj_flag    <= 1'b0;
      inv_r       <= 1'b0;
      shreg       <= '0;
      data_out    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= cnt_nxt;
      inj_flag    <= inj_nxt;
      inv_r       <= inv_nxt;
      shreg       <= sh_nxt;
      data_out    <= d_nxt;
      frame_start <= fs_nxt;
      underrun    <= ur_nxt;
    end
  end

  // Next state / bit counter. tx_en is only looked at in IDLE and on the
  // last bit of a frame, so dropping it mid-frame never truncates a frame.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (tx_en) state_nxt = HEAD;
      end
      HEAD: begin
        cnt_nxt = bit_cnt + CW'(1);
        if (bit_cnt == CW'(HEAD_LEN - 1)) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (bit_cnt == CW'(FRAME_LEN - 1)) begin
          cnt_nxt   = '0;
          state_nxt = tx_en ? HEAD : IDLE;
        end else begin
          cnt_nxt = bit_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs, computed for the upcoming state/bit_cnt.
  always_comb begin
    start_nxt = (state_nxt == HEAD) && (cnt_nxt == '0);
    load_nxt  = (state_nxt == PAYLOAD) && (cnt_nxt[2:0] == 3'd0);
    pop       = load_nxt && buf_valid;

    // err_inject in the frame-start cycle still counts for that frame.
    inv_nxt = start_nxt ? (inj_flag | err_inject) : inv_r;
    inj_nxt = start_nxt ? 1'b0 : (inj_flag | err_inject);

    // A byte handshaken in a load cycle is not yet in buf_valid, so that
    // load falls back to the fill byte.
    sh_nxt  = load_nxt ? (buf_valid ? buf_data : FILL_BYTE) : {shreg[BYTE_W-2:0], 1'b0};
    ur_nxt  = load_nxt && !buf_valid;
    fs_nxt  = start_nxt;

    head_sh = HEAD_PATTERN << cnt_nxt;
    case (state_nxt)
      HEAD:    d_nxt = head_sh[HEAD_LEN-1] ^ inv_nxt;
      PAYLOAD: d_nxt = sh_nxt[BYTE_W-1];
      default: d_nxt = 1'b0;
    endcase
  end

endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
- Serial frame transmitter. It is the transmit end of the 64-bit framed link whose receiver hunts for the 8-bit head 01111110.
- Builds each frame as an 8-bit head followed by 56 payload bits (7 bytes, MSB first), and emits one bit per clk_out cycle.
- Accepts payload bytes through a valid/ready handshake. If no byte is available when one is needed, it sends a fill byte in its place.
- Can deliberately corrupt one frame head on request, to exercise receiver loss-of-sync and recovery.

Parameters:
- FRAME_LEN, 64: total bits per frame. (FRAME_LEN - HEAD_LEN) must be a multiple of 8.
- HEAD_LEN, 8: frame head length in bits.
- HEAD_PATTERN, 8'b01111110: frame head, transmitted MSB first.
- FILL_BYTE, 8'h00: byte substituted on payload underrun.

Ports:
- clk_out  in  1  bit clock
- rst_n  in  1  synchronous reset, active-low
- tx_en  in  1  enable framing; sampled at frame boundaries only
- pay_data  in  8  payload byte
- pay_valid  in  1  pay_data valid
- pay_ready  out  1  byte accepted when pay_valid && pay_ready
- err_inject  in  1  request an inverted head on the next frame
- data_out  out  1  serial line, registered
- frame_start  out  1  pulse, high while data_out carries head bit 0
- underrun  out  1  pulse, high while data_out carries MSB of a fill byte
- tx_busy  out  1  high in HEAD/PAYLOAD states

Behaviour:
- One clock, clk_out. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at posedge):
  - state=IDLE; bit_cnt=0.
  - data_out, frame_start, underrun, tx_busy, pay_ready all 0.
  - Byte buffer empty; inject flag cleared.
  - Reset mid-frame aborts the frame immediately; no partial completion.
- Byte buffer: a 1-entry holding register plus a valid flag.
  - pay_ready = rst_n && !buf_valid && (tx_en || tx_busy).
  - A handshake fills the buffer.
  - Loading the shift register empties the buffer in the same cycle. pay_ready may re-assert the following cycle; no same-cycle load and refill.
- err_inject: a 1-cycle high pulse sets the inject flag, which is sticky until consumed at the next frame start.
- State machine:
  - IDLE:
    - data_out=0.
    - If tx_en=1, go to HEAD with bit_cnt=0. The next cycle shows head bit 0 on data_out, with frame_start=1.
    - Latency is 1 cycle from sampling tx_en=1.
  - HEAD, bit_cnt 0..HEAD_LEN-1:
    - data_out = HEAD_PATTERN[HEAD_LEN-1-bit_cnt].
    - If the inject flag was set when the frame started, the whole head is inverted (10000001); the flag clears at frame start.
    - Inject arriving during a frame takes effect on the next frame.
  - PAYLOAD, bit_cnt HEAD_LEN..FRAME_LEN-1:
    - When bit_cnt[2:0]==0, load the shift register from the buffer if buf_valid; otherwise load FILL_BYTE and assert underrun.
    - data_out = shift MSB in the load cycle, then shift left each cycle.
  - Frame end (bit_cnt=FRAME_LEN-1):
    - If tx_en=1, bit_cnt wraps to 0 and HEAD follows with no gap (back-to-back frames).
    - Else return to IDLE.
    - tx_en deasserted mid-frame does not truncate the frame.
- Frame period: exactly FRAME_LEN cycles, so head starts repeat every 64 cycles. This matches the receiver's 64-bit check interval.
- Simultaneous events:
  - A handshake in the same cycle as a load point does not satisfy that load; the byte is used at the next load point.
  - err_inject high in the frame-start cycle applies to that frame.

Decomposition:
- Shared package holds:
  - frame constants (FRAME_LEN, HEAD_LEN, HEAD_PATTERN);
  - the state encoding IDLE/HEAD/PAYLOAD;
  - constants shared with the receiver, so both ends use one head definition.
- One sub-module: sync_frame_tx_bytebuf (1-entry valid/ready holding register). Counter, FSM and shift register live in the top module.

Test Plan:
- Reset then tx_en=1 with bytes 0x11,0x22,...,0x77 pre-offered -> data_out shows 01111110 then 0001000100100010...01110111. frame_start high on cycle 1 only; underrun never asserts.
- pay_valid held 0 for a whole frame -> head is correct, payload is 56 zeros, underrun pulses 7 times at bit_cnt 8,16,...,56.
- tx_en dropped at bit_cnt 20 -> the frame completes all 64 bits, then IDLE with data_out=0 and tx_busy=0. tx_en re-raised -> new head 1 cycle later.
- err_inject pulse during frame N -> frame N+1 head = 10000001 while payload is unaffected. Frame N+2 head = 01111110.
- rst_n=0 at bit_cnt 30 -> next cycle data_out=0, tx_busy=0, buffer empty. Re-enable restarts from head bit 0.
- Loopback into the receiver with continuous frames -> receiver synchronized after the 3rd head. A single injected bad head -> receiver leaves synchronized but regains it on the next good head.
